// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder/subtractor
// with group generate/propagate and valid/ready flow control.
module cla_adder_pipe #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     carry_in,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     carry_out,
    output logic                     overflow,
    output logic [WIDTH/GROUP-1:0]   group_p
);

    localparam int NG = WIDTH / GROUP;

    if (GROUP < 1) begin : g_bad_group
        $error("cla_adder_pipe: GROUP must be >= 1");
    end else if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
    end

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;
    logic             c0_c;
    logic [NG-1:0]    gg_c;
    logic [NG-1:0]    gp_c;

    logic             v1;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic [NG-1:0]    gg1;
    logic [NG-1:0]    gp1;
    logic             c0_1;
    logic             a_msb1;
    logic             b_msb1;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] c_bit;
    logic [WIDTH-1:0] sum_c;
    logic             ov_c;

    logic             v2;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ov_q;
    logic [NG-1:0]    gp_q;

    logic             adv2;

    assign adv2     = !v2 || out_ready;
    assign in_ready = !v1 || adv2;

    // Condition operands and form bit-level generate/propagate.
    always_comb begin
        b_eff = b ^ {WIDTH{sub}};
        c0_c  = sub | carry_in;
        g_c   = a & b_eff;
        p_c   = a ^ b_eff;
    end

    // Per-group generate/propagate from the bit-level terms.
    always_comb begin
        logic gacc;
        logic pacc;
        gg_c = '0;
        gp_c = '0;
        for (int k = 0; k < NG; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gacc = g_c[k*GROUP+j] | (p_c[k*GROUP+j] & gacc);
                pacc = pacc & p_c[k*GROUP+j];
            end
            gg_c[k] = gacc;
            gp_c[k] = pacc;
        end
    end

    // Stage 1: capture generate/propagate terms when the pipe can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            g1     <= '0;
            p1     <= '0;
            gg1    <= '0;
            gp1    <= '0;
            c0_1   <= 1'b0;
            a_msb1 <= 1'b0;
            b_msb1 <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                g1     <= g_c;
                p1     <= p_c;
                gg1    <= gg_c;
                gp1    <= gp_c;
                c0_1   <= c0_c;
                a_msb1 <= a[WIDTH-1];
                b_msb1 <= b_eff[WIDTH-1];
            end
        end
    end

    // Group carries as flat sum-of-products across all lower groups.
    always_comb begin
        logic acc;
        logic pr;
        gc    = '0;
        gc[0] = c0_1;
        for (int k = 1; k <= NG; k++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int m = k - 1; m >= 0; m--) begin
                acc = acc | (gg1[m] & pr);
                pr  = pr & gp1[m];
            end
            gc[k] = acc | (c0_1 & pr);
        end
    end

    // Intra-group carries, sum and signed overflow.
    always_comb begin
        logic acc;
        logic pr;
        c_bit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int m = i - 1; m >= (i / GROUP) * GROUP; m--) begin
                acc = acc | (g1[m] & pr);
                pr  = pr & p1[m];
            end
            c_bit[i] = acc | (gc[i/GROUP] & pr);
        end
        sum_c = p1 ^ c_bit;
        ov_c  = (a_msb1 == b_msb1) && (sum_c[WIDTH-1] != a_msb1);
    end

    // Stage 2: register the resolved result; hold it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
            gp_q  <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sum_q <= sum_c;
                co_q  <= gc[NG];
                ov_q  <= ov_c;
                gp_q  <= gp1;
            end
        end
    end

    assign out_valid = v2;
    assign sum       = sum_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
    assign group_p   = gp_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: scoreboard bench for cla_adder_pipe
// across 8/4, 16/4 and 12/3 configurations.
module tb_cla_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] a         [3];
    logic [15:0] b         [3];
    logic        cin       [3];
    logic        sub       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] sum_w     [3];
    logic        co_w      [3];
    logic        ov_w      [3];
    logic [3:0]  gp_w      [3];

    logic [21:0] exp_q [3][$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    for (genvar ci = 0; ci < 3; ci++) begin : g_cfg
        localparam int W = (ci == 0) ? 8 : (ci == 1) ? 16 : 12;
        localparam int G = (ci == 2) ? 3 : 4;
        logic [W-1:0]   s;
        logic [W/G-1:0] gpv;
        logic           co;
        logic           ov;

        cla_adder_pipe #(.WIDTH(W), .GROUP(G)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[ci]),
            .in_ready  (in_ready[ci]),
            .a         (a[ci][W-1:0]),
            .b         (b[ci][W-1:0]),
            .carry_in  (cin[ci]),
            .sub       (sub[ci]),
            .out_valid (out_valid[ci]),
            .out_ready (out_ready[ci]),
            .sum       (s),
            .carry_out (co),
            .overflow  (ov),
            .group_p   (gpv)
        );

        assign sum_w[ci] = 16'(s);
        assign gp_w[ci]  = 4'(gpv);
        assign co_w[ci]  = co;
        assign ov_w[ci]  = ov;
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_w(input int ci);
        return (ci == 0) ? 8 : (ci == 1) ? 16 : 12;
    endfunction

    function automatic int cfg_g(input int ci);
        return (ci == 2) ? 3 : 4;
    endfunction

    function automatic logic [21:0] pk(input logic [15:0] s, input logic co,
                                       input logic ov, input logic [3:0] gp);
        return {gp, ov, co, s};
    endfunction

    // Reference: plain integer add of the conditioned operands.
    function automatic logic [21:0] model(input int w, input int g,
                                          input logic [15:0] av,
                                          input logic [15:0] bv,
                                          input logic c, input logic s);
        logic [31:0] mask;
        logic [31:0] gm;
        logic [31:0] aa;
        logic [31:0] be;
        logic [31:0] full;
        logic [31:0] pv;
        logic [15:0] sm;
        logic        co;
        logic        ov;
        logic [3:0]  gp;
        mask = (32'd1 << w) - 32'd1;
        gm   = (32'd1 << g) - 32'd1;
        aa   = {16'd0, av} & mask;
        be   = ({16'd0, bv} ^ (s ? mask : 32'd0)) & mask;
        full = aa + be + {31'd0, (s | c)};
        sm   = full[15:0] & mask[15:0];
        co   = full[w];
        ov   = (aa[w-1] == be[w-1]) && (sm[w-1] != aa[w-1]);
        pv   = aa ^ be;
        gp   = '0;
        for (int k = 0; k < w / g; k++)
            gp[k] = (((pv >> (k * g)) & gm) == gm);
        return {gp, ov, co, sm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // Drive one operand set, wait for acceptance, then log its expectation.
    task automatic send(input int ci, input logic [15:0] av,
                        input logic [15:0] bv, input logic c, input logic s,
                        input logic [21:0] e, output int tries);
        logic r;
        a[ci]        = av;
        b[ci]        = bv;
        cin[ci]      = c;
        sub[ci]      = s;
        in_valid[ci] = 1'b1;
        tries        = 0;
        r            = 1'b0;
        while (!r && tries < 50) begin
            tries++;
            @(negedge clk);
            r = in_ready[ci];
            @(posedge clk);
            #1;
        end
        if (r) exp_q[ci].push_back(e);
        else chk("send_timeout", 32'(tries), 32'd1);
    endtask

    task automatic wait_empty(input int ci);
        int n;
        n = 0;
        while (exp_q[ci].size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("drain%0d", ci), 32'(exp_q[ci].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a result transfers.
    always @(negedge clk) begin
        logic [21:0] e;
        logic [21:0] act;
        for (int ci = 0; ci < 3; ci++) begin
            if (out_valid[ci] && out_ready[ci]) begin
                total_cnt++;
                act = {gp_w[ci], ov_w[ci], co_w[ci], sum_w[ci]};
                if (exp_q[ci].size() == 0) begin
                    $display("FAIL res%0d: got unexpected %0h required none",
                             ci, act);
                end else begin
                    e = exp_q[ci].pop_front();
                    if (act === e) pass_cnt++;
                    else $display("FAIL res%0d: got %0h required %0h",
                                  ci, act, e);
                end
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] bp_a [3];
    logic [15:0] bp_b [3];
    logic        bp_s [3];
    logic [21:0] bp_e [3];

    initial begin
        int t;
        int stalls;
        int acc;
        logic r;
        logic [15:0] av;
        logic [15:0] bv;
        logic        cv;
        logic        sv;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            a[i]         = '0;
            b[i]         = '0;
            cin[i]       = 1'b0;
            sub[i]       = 1'b0;
        end

        #3;
        chk("rst_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_outs", 32'({gp_w[0], ov_w[0], co_w[0], sum_w[0]}), 32'd0);
        chk("rst_ready", 32'(in_ready[0]), 32'd1);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap-around with latency probe.
        send(0, 16'hFF, 16'h01, 1'b0, 1'b0, pk(16'h00, 1, 0, 4'b10), t);
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_early", 32'(out_valid[0]), 32'd0);
        @(negedge clk);
        chk("lat_two", 32'(out_valid[0]), 32'd1);
        @(posedge clk);
        #1;

        // Signed overflow, then subtract ignoring carry_in.
        send(0, 16'h7F, 16'h01, 1'b0, 1'b0, pk(16'h80, 0, 1, 4'b00), t);
        send(0, 16'h05, 16'h07, 1'b1, 1'b1, pk(16'hFE, 0, 0, 4'b10), t);
        send(0, 16'h80, 16'h01, 1'b0, 1'b1, pk(16'h7F, 1, 1, 4'b00), t);
        send(0, 16'h30, 16'h30, 1'b0, 1'b1, pk(16'h00, 1, 0, 4'b11), t);
        in_valid[0] = 1'b0;
        wait_empty(0);

        // Back-to-back streaming.
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            av = 16'($urandom_range(0, 255));
            bv = 16'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
            sv = 1'($urandom_range(0, 1));
            send(0, av, bv, cv, sv, model(8, 4, av, bv, cv, sv), t);
            if (t != 1) stalls++;
        end
        in_valid[0] = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'd0);
        wait_empty(0);

        // Backpressure: consumer stalls for 4 cycles.
        bp_a[0] = 16'h12; bp_b[0] = 16'h34; bp_s[0] = 1'b0;
        bp_e[0] = pk(16'h46, 0, 0, 4'b00);
        bp_a[1] = 16'h80; bp_b[1] = 16'h01; bp_s[1] = 1'b1;
        bp_e[1] = pk(16'h7F, 1, 1, 4'b00);
        bp_a[2] = 16'h01; bp_b[2] = 16'h01; bp_s[2] = 1'b0;
        bp_e[2] = pk(16'h02, 0, 0, 4'b00);
        out_ready[0] = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            a[0]        = bp_a[(acc < 3) ? acc : 2];
            b[0]        = bp_b[(acc < 3) ? acc : 2];
            sub[0]      = bp_s[(acc < 3) ? acc : 2];
            cin[0]      = 1'b0;
            in_valid[0] = 1'b1;
            @(negedge clk);
            r = in_ready[0];
            @(posedge clk);
            #1;
            if (r) begin
                exp_q[0].push_back(bp_e[(acc < 3) ? acc : 2]);
                acc++;
            end
        end
        in_valid[0] = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_ready_low", 32'(in_ready[0]), 32'd0);
        chk("bp_valid", 32'(out_valid[0]), 32'd1);
        chk("bp_hold",
            32'({gp_w[0], ov_w[0], co_w[0], sum_w[0]}), 32'(bp_e[0]));
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_empty(0);
        @(negedge clk);
        chk("bp_ready_back", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset with two results in flight.
        send(0, 16'h11, 16'h22, 1'b0, 1'b0, pk(16'h33, 0, 0, 4'b00), t);
        send(0, 16'h44, 16'h11, 1'b0, 1'b0, pk(16'h55, 0, 0, 4'b00), t);
        in_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_rst_outs",
            32'({gp_w[0], ov_w[0], co_w[0], sum_w[0]}), 32'd0);
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, 16'hA5, 16'h5A, 1'b1, 1'b0, pk(16'h00, 1, 0, 4'b11), t);
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_early", 32'(out_valid[0]), 32'd0);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid[0]), 32'd1);
        wait_empty(0);

        // Wider and odd-group configurations.
        for (int ci = 1; ci < 3; ci++) begin
            stalls = 0;
            send(ci, 16'hFFFF, 16'h0001, 1'b0, 1'b0,
                 model(cfg_w(ci), cfg_g(ci), 16'hFFFF, 16'h0001, 0, 0), t);
            for (int i = 0; i < 24; i++) begin
                av = 16'($urandom_range(0, 65535));
                bv = 16'($urandom_range(0, 65535));
                cv = 1'($urandom_range(0, 1));
                sv = 1'($urandom_range(0, 1));
                send(ci, av, bv, cv, sv,
                     model(cfg_w(ci), cfg_g(ci), av, bv, cv, sv), t);
                if (t != 1) stalls++;
            end
            in_valid[ci] = 1'b0;
            chk($sformatf("sweep%0d_stalls", ci), 32'(stalls), 32'd0);
            wait_empty(ci);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
